// File: rtl/fusion_stream_ctrl.sv
// Stream controller wrapped around a stallable fusion pipeline: accepts source beats, tracks their
// validity through the pipe, and frames the output stream. `FUSION_STREAM_PERF_EN adds perf counters.
module fusion_stream_ctrl #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int INPUT_WIDTH     = 8,
  parameter int IMAGE_DIM       = 512,
  parameter int PIPE_LATENCY    = 23,
  parameter int DATA_WIDTH      = INPUT_WIDTH * PIXELS_PER_BEAT
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  stall,
  input  logic [DATA_WIDTH-1:0] fused_frame,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  frame_done
`ifdef FUSION_STREAM_PERF_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           frame_cycles
`endif
);

  localparam int BEATS = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [PIPE_LATENCY-1:0] valid_sr_q, valid_sr_d;
  logic [CNT_W-1:0]        in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]        out_cnt_q, out_cnt_d;
  logic                    m_tvalid_q;
  logic [DATA_WIDTH-1:0]   m_tdata_q;
  logic                    frame_done_q;
  logic                    accept, hs, last_hs;

  assign stall      = m_tvalid_q & ~m_tready;
  assign s_ready    = ~stall & (state_q != FLUSH);
  assign accept     = s_valid & s_ready;
  assign hs         = m_tvalid_q & m_tready;
  assign m_tlast    = m_tvalid_q & (out_cnt_q == LAST_BEAT);
  assign last_hs    = hs & m_tlast;
  assign m_tvalid   = m_tvalid_q;
  assign m_tdata    = m_tdata_q;
  assign frame_done = frame_done_q;

  // FLUSH holds off input so only one frame is ever inside the fusion pipe.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (in_cnt_q == LAST_BEAT) ? FLUSH : RUN;
      RUN:     if (accept && (in_cnt_q == LAST_BEAT)) state_d = FLUSH;
      FLUSH:   if (last_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_sr_d    = valid_sr_q << 1;
    valid_sr_d[0] = accept;
    in_cnt_d      = in_cnt_q;
    out_cnt_d     = out_cnt_q;
    if (accept) in_cnt_d = (in_cnt_q == LAST_BEAT) ? '0 : in_cnt_q + 1'b1;
    if (hs)     out_cnt_d = (out_cnt_q == LAST_BEAT) ? '0 : out_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q      <= IDLE;
      valid_sr_q   <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      m_tvalid_q   <= 1'b0;
      m_tdata_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      frame_done_q <= last_hs;
      // The valid tracker and output register freeze together with the fusion pipe.
      if (!stall) begin
        valid_sr_q <= valid_sr_d;
        m_tvalid_q <= valid_sr_q[PIPE_LATENCY-1];
        m_tdata_q  <= fused_frame;
      end
    end
  end

`ifdef FUSION_STREAM_PERF_EN
  logic [31:0] stall_cycles_q, frame_cycles_q, run_cycles_q;
  logic        timing_q;

  // A new frame may start in the same cycle the previous frame_done pulses; the restart wins.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      stall_cycles_q <= '0;
      frame_cycles_q <= '0;
      run_cycles_q   <= '0;
      timing_q       <= 1'b0;
    end else begin
      if (stall && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (frame_done_q) begin
        frame_cycles_q <= run_cycles_q;
        timing_q       <= 1'b0;
      end
      if ((state_q == IDLE) && accept) begin
        timing_q     <= 1'b1;
        run_cycles_q <= 32'd1;
      end else if (timing_q && (run_cycles_q != '1)) begin
        run_cycles_q <= run_cycles_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign frame_cycles = frame_cycles_q;
`endif

endmodule

// File: tb/tb_fusion_stream_ctrl.sv
// Bench for fusion_stream_ctrl with an 8x8 image (4 beats per frame): a fusion-pipe stand-in feeds
// fused_frame, and a scoreboard checks order, latency, framing and backpressure every cycle.
module tb_fusion_stream_ctrl;
  localparam int PPB   = 16;
  localparam int IW    = 8;
  localparam int DIM   = 8;
  localparam int PL    = 23;
  localparam int DW    = IW * PPB;
  localparam int BEATS = DIM * DIM / PPB;

  logic          clk = 1'b0;
  logic          areset = 1'b1;
  logic          s_valid = 1'b0;
  logic          m_tready = 1'b1;
  logic          s_ready, stall, m_tvalid, m_tlast, frame_done;
  logic [DW-1:0] fused_frame, m_tdata;
`ifdef FUSION_STREAM_PERF_EN
  logic [31:0]   stall_cycles, frame_cycles;
`endif

  fusion_stream_ctrl #(
    .PIXELS_PER_BEAT(PPB), .INPUT_WIDTH(IW), .IMAGE_DIM(DIM), .PIPE_LATENCY(PL)
  ) dut (
    .clk(clk), .areset(areset), .s_valid(s_valid), .s_ready(s_ready), .stall(stall),
    .fused_frame(fused_frame), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .frame_done(frame_done)
`ifdef FUSION_STREAM_PERF_EN
    , .stall_cycles(stall_cycles), .frame_cycles(frame_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference state: expected beat payloads in order, accept timestamps in enabled cycles,
  // position within the frame on both sides, and whether the current frame is fully accepted.
  logic [DW-1:0] exp_q[$];
  int            stamp_q[$];
  int            start_cyc[$];
  int            tlast_cyc[$];
  int            en_cnt = 0, beat_idx = 0, acc_in_frame = 0;
  int            acc_total = 0, hs_total = 0, tlast_total = 0, fd_total = 0, stall_seen = 0;
  int            cyc = 0;
  bit            in_flush = 0, fd_exp = 0, prev_en = 0, prev_stall = 0;
  bit            st_exp, sr_exp, tl_exp, hs_now;
  logic [DW-1:0] prev_tdata;
  bit            acc_n = 0, stall_n = 0;
  logic [DW-1:0] acc_data_n;
  logic [DW-1:0] pipe [PL];

  // Stand-in for the fusion pipeline: freezes on stall, carries the accepted payload.
  assign fused_frame = pipe[PL-1];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (areset) begin
      for (int i = 0; i < PL; i++) pipe[i] <= '0;
    end else if (!stall_n) begin
      for (int i = PL - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= acc_n ? acc_data_n : rand_word();
    end
  end

  always @(negedge clk) begin
    if (areset) begin
      acc_n = 0; stall_n = 0; prev_en = 0; prev_stall = 0;
      exp_q.delete(); stamp_q.delete();
      beat_idx = 0; acc_in_frame = 0; in_flush = 0; fd_exp = 0;
    end else begin
      st_exp = m_tvalid && !m_tready;
      check("stall", stall, st_exp);
      sr_exp = !st_exp && !in_flush;
      check("s_ready", s_ready, sr_exp);
      tl_exp = m_tvalid && (beat_idx == BEATS - 1);
      check("m_tlast", m_tlast, tl_exp);
      check("frame_done", frame_done, fd_exp);
      if (frame_done) fd_total++;
      if (m_tvalid && prev_en) begin
        if (stamp_q.size() == 0) check("extra_beat", stamp_q.size(), 1);
        else check("latency", en_cnt - stamp_q.pop_front(), PL + 1);
      end
      if (m_tvalid && prev_stall) check("hold_tdata", m_tdata, prev_tdata);
      hs_now = m_tvalid && m_tready;
      fd_exp = hs_now && tl_exp;
      if (hs_now) begin
        if (exp_q.size() == 0) check("dup_beat", exp_q.size(), 1);
        else check("tdata", m_tdata, exp_q.pop_front());
        hs_total++;
        if (tl_exp) begin
          tlast_total++;
          tlast_cyc.push_back(cyc);
          in_flush = 0;
        end
        beat_idx = (beat_idx + 1) % BEATS;
      end
      acc_n = s_valid && s_ready;
      if (acc_n) begin
        acc_data_n = rand_word();
        exp_q.push_back(acc_data_n);
        stamp_q.push_back(en_cnt);
        if (acc_in_frame == 0) start_cyc.push_back(cyc);
        acc_total++;
        acc_in_frame++;
        if (acc_in_frame == BEATS) begin
          acc_in_frame = 0;
          in_flush = 1;
        end
      end
      stall_n = stall;
      if (stall) stall_seen++;
      if (!st_exp) en_cnt++;
      prev_en = !st_exp;
      prev_stall = st_exp;
      prev_tdata = m_tdata;
    end
  end

  // vmode: 0 continuous, 1 alternating. rmode: 0 always ready, 2 random 50%, 3 one 5-cycle stall.
  task automatic run(input int n, input int vmode, input int rmode, input int hs_stop);
    int  acc_goal = acc_total + n;
    int  hs_goal  = hs_total + hs_stop;
    int  budget   = 0;
    int  hold     = 0;
    bit  stalled_once = 0;
    bit  tog = 1;
    while (hs_total < hs_goal && budget < 2000) begin
      @(posedge clk); #1;
      budget++;
      s_valid = (acc_total < acc_goal) && (vmode == 0 || tog);
      tog = !tog;
      case (rmode)
        2: m_tready = 1'($urandom_range(0, 1));
        3: begin
          if (!stalled_once && m_tvalid) begin
            stalled_once = 1;
            hold = 5;
          end
          if (hold > 0) begin
            m_tready = 1'b0;
            hold--;
          end else begin
            m_tready = 1'b1;
          end
        end
        default: m_tready = 1'b1;
      endcase
    end
    check("run_done", hs_total, hs_goal);
    s_valid  = 1'b0;
    m_tready = 1'b1;
  endtask

  int base_a, base_b, base_c;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_stall", stall, 0);
    check("rst_s_ready", s_ready, 1);
    areset = 1'b0;

    // Two back-to-back frames with s_valid held high through the final handshake.
    run(2 * BEATS, 0, 0, 2 * BEATS);
    repeat (2) @(posedge clk); #1;
    check("frames_tlast", tlast_total, 2);
    check("frames_done", fd_total, 2);
    check("restart_gap", start_cyc[1] - tlast_cyc[0], 1);

    // Five-cycle backpressure while the first output beat is valid.
    base_a = stall_seen;
`ifdef FUSION_STREAM_PERF_EN
    base_b = stall_cycles;
`endif
    run(BEATS, 0, 3, BEATS);
    repeat (2) @(posedge clk); #1;
    check("stall_len", stall_seen - base_a, 5);
`ifdef FUSION_STREAM_PERF_EN
    check("perf_stall_cycles", stall_cycles - base_b, 5);
`endif

    // Alternating source valid inserts bubbles into the pipe.
    base_a = tlast_total;
    run(BEATS, 1, 0, BEATS);
    repeat (2) @(posedge clk); #1;
    check("alt_tlast", tlast_total - base_a, 1);

    // Three frames under random backpressure.
    base_a = tlast_total; base_b = fd_total; base_c = hs_total;
    run(3 * BEATS, 0, 2, 3 * BEATS);
    repeat (2) @(posedge clk); #1;
    check("rand_beats", hs_total - base_c, 3 * BEATS);
    check("rand_tlast", tlast_total - base_a, 3);
    check("rand_done", fd_total - base_b, 3);

    // Reset mid-frame after two output beats.
    run(BEATS, 0, 0, 2);
    areset = 1'b1;
    #1;
    check("mid_rst_m_tvalid", m_tvalid, 0);
    check("mid_rst_m_tlast", m_tlast, 0);
    check("mid_rst_frame_done", frame_done, 0);
    check("mid_rst_m_tdata", m_tdata, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_s_ready", s_ready, 1);
`ifdef FUSION_STREAM_PERF_EN
    check("mid_rst_stall_cycles", stall_cycles, 0);
    check("mid_rst_frame_cycles", frame_cycles, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    areset = 1'b0;
    base_a = tlast_total; base_b = fd_total;
    run(BEATS, 0, 0, BEATS);
    repeat (2) @(posedge clk); #1;
    check("post_rst_tlast", tlast_total - base_a, 1);
    check("post_rst_done", fd_total - base_b, 1);
    check("drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fusion_stream_ctrl.md
FUSION_STREAM_CTRL -- requirements
Module: fusion_stream_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- PIXELS_PER_BEAT, 16, pixels per beat.
- INPUT_WIDTH, 8, bits per pixel.
- IMAGE_DIM, 512, frame side in pixels.
- PIPE_LATENCY, 23, enabled cycles from input accept to valid fused_frame.
- DATA_WIDTH = INPUT_WIDTH*PIXELS_PER_BEAT, derived.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the only clock.
- areset, in, 1, asynchronous active-high reset.
- s_valid, in, 1, source beat available.
- s_ready, out, 1, beat accepted into the fusion pipe.
- stall, out, 1, freeze for the fusion pipeline.
- fused_frame, in, DATA_WIDTH, fusion pipeline output.
- m_tdata, out, DATA_WIDTH, output stream data.
- m_tvalid, out, 1, output stream valid.
- m_tready, in, 1, output stream ready.
- m_tlast, out, 1, last beat of frame.
- frame_done, out, 1, one-cycle pulse when the last beat is accepted.
REQ-003 The block SHALL define BEATS = IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT, which must be an integer.

Function
REQ-004 stall SHALL be the combinational value m_tvalid & ~m_tready.
REQ-005 s_ready SHALL be ~stall & (state != FLUSH); an input beat is accepted when s_valid & s_ready.
REQ-006 A PIPE_LATENCY-bit valid shift register SHALL advance only when ~stall; bit 0 loads the accept flag, so an idle s_valid inserts a bubble.
REQ-007 On each ~stall edge, m_tvalid SHALL load valid_sr[PIPE_LATENCY-1] and m_tdata SHALL load fused_frame; both SHALL hold while stall.
REQ-008 The input beat counter SHALL count accepts over 0..BEATS-1 and then wrap to 0.
REQ-009 The output beat counter SHALL count m_tvalid&m_tready handshakes over 0..BEATS-1 and then wrap to 0.
REQ-010 m_tlast SHALL equal m_tvalid & (output count == BEATS-1).
REQ-011 frame_done SHALL be registered and pulse high for exactly one cycle after the handshake with m_tlast=1.
REQ-012 The FSM SHALL have the states IDLE, RUN and FLUSH:
- IDLE->RUN on the first accept.
- RUN->FLUSH on the accept of input beat BEATS-1.
- FLUSH->IDLE on the handshake with m_tlast.
REQ-013 FLUSH SHALL block new input so that at most one frame is in flight; this lets the frame-level maps change between frames.
REQ-014 If the input accept and the final output handshake fall on the same cycle, the FSM SHALL go FLUSH->IDLE and the accept SHALL not occur, because s_ready is 0 in FLUSH.
REQ-015 Latency SHALL be PIPE_LATENCY+1 enabled cycles from accept to m_tvalid; stalled cycles SHALL not count.
REQ-016 When BEATS==1, the accept SHALL go IDLE->FLUSH directly.
REQ-017 No beat SHALL be dropped or duplicated under any pattern of m_tready.

Reset
REQ-018 While areset=1, all of the following SHALL hold, asynchronously:
- m_tvalid=0, m_tlast=0, frame_done=0, m_tdata=0.
- valid_sr=0, both counters=0, state=IDLE.
REQ-019 While areset=1, stall SHALL read 0 and s_ready SHALL read 1.
REQ-020 A reset mid-frame SHALL discard all in-flight beats; the first accept after reset SHALL be beat 0 of a new frame.

Configuration
REQ-021 When FUSION_STREAM_PERF_EN is defined, the block SHALL add the following 32-bit outputs:
- stall_cycles: increments each cycle stall=1.
- frame_cycles: cycles from IDLE->RUN to frame_done, latched on frame_done.
- Both SHALL reset to 0 and saturate at all-ones.
REQ-022 Without FUSION_STREAM_PERF_EN, these ports and counters SHALL not exist, and all other behaviour SHALL be identical.

Verification
REQ-023 The bench SHALL use IMAGE_DIM=8 and PIXELS_PER_BEAT=16, giving BEATS=4, and cover:
- s_valid=1 continuously, m_tready=1 -> first m_tvalid 24 cycles after the first accept; 4 beats; m_tlast on beat 3; frame_done one cycle later; s_ready=0 from the 5th cycle until drain.
- m_tready=0 for 5 cycles while m_tvalid=1 -> stall=1 and m_tdata stable for 5 cycles; beat order intact; stall_cycles=5 (PERF_EN).
- s_valid alternating 1/0 -> bubbles preserved; m_tvalid alternates; output count reaches 3 only on the 4th valid beat.
- m_tready random at 50% over 3 frames -> 12 beats in order, exactly 3 m_tlast and 3 frame_done pulses, none lost.
- areset asserted after 2 output beats -> all outputs 0 immediately; next frame tlast on its 4th beat.
- Last-beat handshake with s_valid=1 on the same cycle -> state IDLE; the next frame's accept occurs one cycle later.
